// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: warp and PC sizing, and the {instruction, pc} packet layout
// used by the fetch stage, the fetch/decode register and decode.
package fetch_unit_pkg;

   localparam int NUM_WARP         = 8;
   localparam int NUM_WARP_LOG     = 3;
   localparam int SIZE_PC          = 32;
   localparam int SIZE_INSTRUCTION = 32;
   localparam int SIZE_PACKET      = SIZE_INSTRUCTION + SIZE_PC;

   // Packet field offsets: pc in the low bits, instruction above it.
   localparam int PKT_PC_LSB   = 0;
   localparam int PKT_INST_LSB = SIZE_PC;

   typedef logic [NUM_WARP_LOG-1:0]     warpIdT;
   typedef logic [SIZE_PC-1:0]          pcT;
   typedef logic [SIZE_INSTRUCTION-1:0] instT;
   typedef logic [SIZE_PACKET-1:0]      packetT;

   typedef struct packed {
      logic   valid;
      warpIdT warp;
      pcT     pc;
   } inFlightT;

   typedef struct packed {
      warpIdT warp;
      logic   valid0;
      packetT pkt0;
      logic   valid1;
      packetT pkt1;
   } fetchOutT;

   function automatic packetT makePacket(input instT inst, input pcT pc);
      packetT p;
      p = '0;
      p[PKT_INST_LSB +: SIZE_INSTRUCTION] = inst;
      p[PKT_PC_LSB +: SIZE_PC]            = pc;
      return p;
   endfunction

endpackage

// File: rtl/fetch_unit_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after the pointer, wrapping,
// with the pointer's own warp considered last.
module rr_arbiter
   import fetch_unit_pkg::*;
(
   input  logic [NUM_WARP-1:0] request,
   input  warpIdT              pointer,
   output logic [NUM_WARP-1:0] grant,
   output warpIdT              grantIdx,
   output logic                grantValid
);

   warpIdT candIdx [NUM_WARP];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WARP; gi++) begin : genCand
         assign candIdx[gi] = pointer + NUM_WARP_LOG'(gi + 1);
      end
   endgenerate

   // Scan from the farthest candidate down so the nearest requester wins.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      grant      = '0;
      for (int i = NUM_WARP - 1; i >= 0; i--) begin
         if (request[candIdx[i]]) begin
            grantValid = 1'b1;
            grantIdx   = candIdx[i];
         end
      end
      if (grantValid)
         grant[grantIdx] = 1'b1;
   end

endmodule

// File: rtl/fetch_unit.sv
// Per-warp instruction fetch: round-robin warp select and 8-byte read in F1, packet
// formation in F2 with a one-entry hold buffer behind the downstream stall.
module fetch_unit
   import fetch_unit_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_WARP-1:0]           warpActive_i,
   input  logic                          warpInit_i,
   input  logic [NUM_WARP_LOG-1:0]       warpInitId_i,
   input  logic [SIZE_PC-1:0]            warpInitPc_i,
   output logic                          imemRdEn_o,
   output logic [SIZE_PC-1:0]            imemAddr_o,
   input  logic [2*SIZE_INSTRUCTION-1:0] imemData_i,
   input  logic                          stall_i,
   input  logic                          flush_i,
   input  logic [NUM_WARP_LOG-1:0]       flushWarp_i,
   input  logic [SIZE_PC-1:0]            flushPc_i,
   output logic [NUM_WARP_LOG-1:0]       instWarp_o,
   output logic                          instPacket0Valid_o,
   output logic [SIZE_PACKET-1:0]        instPacket0_o,
   output logic                          instPacket1Valid_o,
   output logic [SIZE_PACKET-1:0]        instPacket1_o
);

   pcT       pcReg  [NUM_WARP];
   pcT       pcNext [NUM_WARP];
   warpIdT   rrPtrReg;
   inFlightT inFlightReg;
   fetchOutT holdReg;
   fetchOutT outReg;
   fetchOutT f2Out;

   logic [NUM_WARP-1:0] flushMask;
   logic [NUM_WARP-1:0] request;
   logic [NUM_WARP-1:0] grant;
   warpIdT              grantIdx;
   logic                grantValid;
   logic                drain;
   logic                issue;
   pcT                  issuePc;
   instT                instLo;
   instT                instHi;
   logic                holdFlushed;
   logic                outFlushed;

   // ---------------- F1: select and address ----------------
   always_comb begin
      flushMask = '0;
      if (flush_i)
         flushMask[flushWarp_i] = 1'b1;
   end

   assign request = warpActive_i & ~flushMask;

   rr_arbiter uArbiter (
      .request    (request),
      .pointer    (rrPtrReg),
      .grant      (grant),
      .grantIdx   (grantIdx),
      .grantValid (grantValid)
   );

   // A draining hold buffer owns the output register, so no new read starts that cycle.
   assign drain      = holdReg.valid0 & ~stall_i;
   assign issue      = ~reset & ~stall_i & ~drain & grantValid;
   assign issuePc    = pcReg[grantIdx];
   assign imemRdEn_o = issue;
   assign imemAddr_o = issue ? {issuePc[SIZE_PC-1:3], 3'b000} : '0;

   // Redirect priority: flush, then init, then the issue advance.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_WARP; gi++) begin : genPc
         assign pcNext[gi] =
            (flush_i    && flushWarp_i  == NUM_WARP_LOG'(gi)) ? flushPc_i :
            (warpInit_i && warpInitId_i == NUM_WARP_LOG'(gi)) ? warpInitPc_i :
            (issue && grant[gi]) ? pcReg[gi] + (pcReg[gi][2] ? SIZE_PC'(4) : SIZE_PC'(8)) :
            pcReg[gi];
      end
   endgenerate

   // ---------------- F2: packet formation ----------------
   assign instLo = imemData_i[SIZE_INSTRUCTION-1:0];
   assign instHi = imemData_i[2*SIZE_INSTRUCTION-1:SIZE_INSTRUCTION];

   always_comb begin
      f2Out = '0;
      if (inFlightReg.valid && !(flush_i && flushWarp_i == inFlightReg.warp)) begin
         f2Out.warp   = inFlightReg.warp;
         f2Out.valid0 = 1'b1;
         if (inFlightReg.pc[2]) begin
            f2Out.pkt0 = makePacket(instHi, inFlightReg.pc);
         end else begin
            f2Out.pkt0   = makePacket(instLo, inFlightReg.pc);
            f2Out.valid1 = 1'b1;
            f2Out.pkt1   = makePacket(instHi, inFlightReg.pc + SIZE_PC'(4));
         end
      end
   end

   assign holdFlushed = flush_i && holdReg.valid0 && flushWarp_i == holdReg.warp;
   assign outFlushed  = flush_i && outReg.valid0  && flushWarp_i == outReg.warp;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_WARP; i++)
            pcReg[i] <= '0;
         rrPtrReg    <= NUM_WARP_LOG'(NUM_WARP - 1);
         inFlightReg <= '0;
         holdReg     <= '0;
         outReg      <= '0;
      end else begin
         for (int i = 0; i < NUM_WARP; i++)
            pcReg[i] <= pcNext[i];
         if (issue) begin
            rrPtrReg    <= grantIdx;
            inFlightReg <= '{valid: 1'b1, warp: grantIdx, pc: issuePc};
         end else begin
            inFlightReg <= '0;
         end

         if (stall_i) begin
            if (f2Out.valid0)
               holdReg <= f2Out;
            else if (holdFlushed)
               holdReg <= '0;
            if (outFlushed)
               outReg <= '0;
         end else if (drain) begin
            holdReg <= '0;
            outReg  <= holdFlushed ? '0 : holdReg;
         end else begin
            outReg <= f2Out;
         end
      end
   end

   assign instWarp_o         = outReg.warp;
   assign instPacket0Valid_o = outReg.valid0;
   assign instPacket0_o      = outReg.pkt0;
   assign instPacket1Valid_o = outReg.valid1;
   assign instPacket1_o      = outReg.pkt1;

endmodule
